// File: rtl/rr_mux81_pkg.sv
// rtl/rr_mux81_pkg.sv - shared constants and output-stage state for the 8:1 round-robin collector
package rr_mux81_pkg;

   localparam int N_CH   = 8;
   localparam int SEL_W  = 3;
   localparam int DEF_DW = 8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - combinational 8-way round-robin grant search starting at ptr
module rr_arbiter8
   import rr_mux81_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             en,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             any
);

   logic [SEL_W-1:0] w_idx;

   // Walk offsets from farthest to nearest so the closest requester at or after ptr wins.
   always_comb begin
      gnt_idx = ptr;
      w_idx   = ptr;
      for (int k = N_CH - 1; k >= 0; k--) begin
         w_idx = ptr + SEL_W'(k);
         if (req[w_idx]) begin
            gnt_idx = w_idx;
         end
      end
   end

   always_comb begin
      any = |req;
      gnt = '0;
      if (en && any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_mux81.sv
// rtl/rr_mux81.sv - 8:1 round-robin collector with a registered valid/ready output stage
module rr_mux81
   import rr_mux81_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH-1:0]      in_valid,
   input  logic [N_CH*DW-1:0]   in_data,
   output logic [N_CH-1:0]      in_ready,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   output logic [SEL_W-1:0]     out_sel,
   input  logic                 out_ready
);

   out_state_e       r_state;
   out_state_e       w_state_nxt;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] r_sel;
   logic [DW-1:0]    r_data;
   logic [N_CH-1:0]  w_gnt;
   logic [SEL_W-1:0] w_gnt_idx;
   logic             w_any;
   logic             w_load_ok;
   logic             w_en;
   logic             w_take;

   // Gating with rst_n keeps in_ready low while reset is held, even though the stage reads EMPTY.
   assign w_load_ok = (r_state == ST_EMPTY) || out_ready;
   assign w_en      = w_load_ok && rst_n;
   assign w_take    = w_en && w_any;

   rr_arbiter8 u_arb (
      .req     (in_valid),
      .ptr     (r_ptr),
      .en      (w_en),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .any     (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_take) w_state_nxt = ST_FULL;
         ST_FULL:  if (!w_take && out_ready) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_sel  <= '0;
         r_ptr  <= '0;
      end else if (w_take) begin
         r_data <= in_data[w_gnt_idx*DW +: DW];
         r_sel  <= w_gnt_idx;
         r_ptr  <= w_gnt_idx + SEL_W'(1);
      end
   end

   assign in_ready  = w_gnt;
   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_data;
   assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_mux81.sv
// tb/tb_rr_mux81.sv - randomized and directed bench for rr_mux81 against a behavioural model
module tb_rr_mux81;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_valid = '0;
   logic [63:0] in_data = '0;
   logic [7:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  out_sel;
   logic        out_ready = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [7:0]  lane_d [8];
   int          mptr;
   logic        mv;
   logic [7:0]  md;
   logic [2:0]  ms;
   logic [10:0] sbq [$];
   int          n_deliv;

   logic        s_valid;
   logic [7:0]  s_data;
   logic [2:0]  s_sel;
   logic [7:0]  s_rdy;

   rr_mux81 #(.DW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mptr = 0;
      mv   = 1'b0;
      md   = '0;
      ms   = '0;
      sbq.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_sel", out_sel, 0);
      check("rst_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = '0;
      rst_n    = 1'b1;
      model_reset();
   endtask

   task automatic step(input logic [7:0] v, input logic rdy);
      logic       load_ok;
      logic [7:0] erdy;
      int         g;
      @(negedge clk);
      in_valid  = v;
      out_ready = rdy;
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = lane_d[i];
      #1;
      s_valid = out_valid;
      s_data  = out_data;
      s_sel   = out_sel;
      s_rdy   = in_ready;
      check("out_valid", out_valid, mv);
      check("out_data", out_data, md);
      check("out_sel", out_sel, ms);
      load_ok = !mv || rdy;
      g = -1;
      erdy = '0;
      if (load_ok) begin
         for (int k = 0; k < 8; k++) begin
            if (g < 0 && v[(mptr + k) % 8]) g = (mptr + k) % 8;
         end
      end
      if (g >= 0) erdy[g] = 1'b1;
      check("in_ready", in_ready, erdy);
      if (mv && rdy) begin
         check("sb_nonempty", sbq.size() != 0, 1);
         if (sbq.size() != 0) check("sb_word", {out_sel, out_data}, sbq.pop_front());
         n_deliv++;
      end
      @(posedge clk);
      if (g >= 0) begin
         md   = lane_d[g];
         ms   = g[2:0];
         mv   = 1'b1;
         mptr = (g + 1) % 8;
         sbq.push_back({ms, md});
      end else if (mv && rdy) begin
         mv = 1'b0;
      end
   endtask

   initial begin
      int base;
      int exp_wrap [4];
      logic [7:0] v;

      model_reset();
      n_deliv = 0;
      for (int i = 0; i < 8; i++) lane_d[i] = 8'h10 + 8'(i);

      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(8'hFF, 1'b1);
         check("t1_rdy", s_rdy, 8'h1 << (i % 8));
         if (i > 0) begin
            check("t1_valid", s_valid, 1);
            check("t1_sel", s_sel, (i - 1) % 8);
            check("t1_data", s_data, 8'h10 + (i - 1) % 8);
         end
      end

      do_reset();
      lane_d[3] = 8'hA5;
      base = n_deliv;
      step(8'h08, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(8'h08, 1'b0);
         check("t2_valid", s_valid, 1);
         check("t2_data", s_data, 8'hA5);
         check("t2_sel", s_sel, 3);
         check("t2_stall_rdy", s_rdy, 0);
      end
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      check("t2_drained", s_valid, 0);
      check("t2_count", n_deliv - base, 1);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(8'h24, 1'b1);
         if (i > 0) check("t3_sel", s_sel, (i % 2 == 1) ? 2 : 5);
      end

      do_reset();
      exp_wrap = '{7, 0, 7, 0};
      step(8'h80, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(8'h81, 1'b1);
         check("t4_sel", s_sel, exp_wrap[i]);
      end

      do_reset();
      lane_d[6] = 8'h3C;
      step(8'h40, 1'b0);
      step(8'h40, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_valid", out_valid, 0);
      check("t5_data", out_data, 0);
      check("t5_sel", out_sel, 0);
      check("t5_rdy", in_ready, 0);
      @(negedge clk);
      in_valid = '0;
      rst_n    = 1'b1;
      model_reset();
      step(8'h81, 1'b1);
      step(8'h00, 1'b1);
      check("t5_first", s_sel, 0);

      do_reset();
      lane_d[1] = 8'h5A;
      lane_d[4] = 8'hC3;
      base = n_deliv;
      step(8'h02, 1'b0);
      step(8'h10, 1'b1);
      check("t6_sel_before", s_sel, 1);
      step(8'h00, 1'b0);
      check("t6_valid", s_valid, 1);
      check("t6_sel_after", s_sel, 4);
      check("t6_data", s_data, 8'hC3);
      check("t6_count", n_deliv - base, 1);

      do_reset();
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 8; i++) lane_d[i] = 8'($urandom);
         v = 8'($urandom) & 8'($urandom);
         if (n % 50 > 40) v = 8'hFF;
         step(v, ($urandom % 4) != 0);
      end
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      check("final_queue", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
